// File: rtl/fetch_unit_pipelined.sv
// Pipelined fetch stage: one outstanding read to a variable-latency instruction
// memory, returned words buffered in a small queue whose head feeds Decode.
module fetch_unit_pipelined #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] PC_STEP  = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall_D,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            valid_D,
  output logic [XLEN-1:0] IR_out_D,
  output logic [XLEN-1:0] PC_D,
  output logic [XLEN-1:0] PC_1D
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(FQ_DEPTH);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] req_pc;

  logic [XLEN-1:0] q_instr [FQ_DEPTH];
  logic [XLEN-1:0] q_pc    [FQ_DEPTH];
  logic [XLEN-1:0] q_pc1   [FQ_DEPTH];
  logic [PW-1:0]   head, tail;
  logic [PW:0]     count;

  logic            accept;
  logic            push;
  logic            pop;
  logic            space;
  logic [PW+1:0]   occ_nxt;

  assign valid_D = (count != '0);
  assign pop     = valid_D & ~stall_D & ~redirect_en;
  assign push    = imem_rvalid & (state == WAIT) & ~redirect_en;

  // Occupancy after this edge; lets a new request go out while a response lands.
  assign occ_nxt = {1'b0, count} + (PW+2)'(push) - (PW+2)'(pop);
  assign space   = (occ_nxt < DEPTH_W);

  assign imem_req  = rst & ~redirect_en & space &
                     ((state == REQ) | ((state == WAIT) & imem_rvalid));
  assign imem_addr = pc;
  assign accept    = imem_req & imem_ready;

  assign IR_out_D = valid_D ? q_instr[head] : '0;
  assign PC_D     = valid_D ? q_pc[head]    : '0;
  assign PC_1D    = valid_D ? q_pc1[head]   : '0;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      REQ: begin
        if (redirect_en) begin
          pc_nxt = redirect_pc;
        end else if (accept) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect_en) begin
          pc_nxt    = redirect_pc;
          state_nxt = imem_rvalid ? REQ : DROP;
        end else if (imem_rvalid) begin
          state_nxt = accept ? WAIT : REQ;
        end
      end
      DROP: begin
        if (redirect_en) begin
          pc_nxt = redirect_pc;
        end
        if (imem_rvalid) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = REQ;
    endcase
    if (accept) begin
      pc_nxt = pc + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= REQ;
      pc     <= RESET_PC;
      req_pc <= '0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (accept) begin
        req_pc <= pc;
      end
      if (redirect_en) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          tail <= tail + 1'b1;
        end
        if (pop) begin
          head <= head + 1'b1;
        end
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      q_instr[tail] <= imem_rdata;
      q_pc[tail]    <= req_pc;
      q_pc1[tail]   <= req_pc + PC_STEP;
    end
  end

endmodule

// File: doc/fetch_unit_pipelined.md
Name: fetch_unit_pipelined

Overview:
- Parametrised successor of the single-cycle fetch stage.
- Issues instruction reads to an external variable-latency instruction memory, with one request outstanding at a time.
- Buffers returned instructions in a FQ_DEPTH-entry fetch queue, and presents the queue head to Decode with a valid flag.
- Handles Decode back-pressure (stall_D) and branch/jump redirects from Execute, killing any in-flight response.

Parameters:
- XLEN, 32, width of PC, addresses and instruction words.
- PC_STEP, 1, PC increment per instruction (word-addressed memory).
- RESET_PC, 0, PC value loaded on reset.
- FQ_DEPTH, 2, fetch queue entries; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-low (rst==0 at a rising clk edge resets the block).
- redirect_en  in  1  Execute redirect (taken branch/jump).
- redirect_pc  in  XLEN  redirect target.
- stall_D  in  1  Decode cannot accept the head instruction this cycle.
- imem_req  out  1  read request.
- imem_addr  out  XLEN  read address (current PC).
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; arrives at least 1 cycle after accept, in order.
- imem_rdata  in  XLEN  instruction word.
- valid_D  out  1  head entry valid.
- IR_out_D  out  XLEN  head instruction.
- PC_D  out  XLEN  head PC.
- PC_1D  out  XLEN  head PC + PC_STEP.

Behaviour:
- Reset (rst==0 at a clk edge):
  - pc <= RESET_PC, state <= REQ, queue emptied, req_pc <= 0.
  - imem_req is 0 during the reset cycle.
  - valid_D, IR_out_D, PC_D and PC_1D are all 0 while the queue is empty, including after reset.
  - Reset overrides every other input. Reset while in WAIT or DROP returns to REQ with nothing outstanding; a late imem_rvalid arriving in REQ is ignored.
- Outputs:
  - valid_D = queue not empty; the other Decode outputs reflect the head entry.
  - pop = valid_D & ~stall_D & ~redirect_en.
- Accept and push:
  - A request is accepted when imem_req & imem_ready. On accept: req_pc <= pc; pc <= pc + PC_STEP (mod 2^XLEN).
  - resp = imem_rvalid & (state==WAIT) & ~redirect_en.
  - On resp, push {instr = imem_rdata, pc = req_pc, pc1 = req_pc + PC_STEP}.
- Issue gating:
  - space = (count - pop + resp) < FQ_DEPTH.
  - imem_req = ~redirect_en & space & ((state==REQ) | (state==WAIT & imem_rvalid)).
  - This allows back-to-back issue in the same cycle a response returns, giving 1 instruction/cycle with 1-cycle memory.
  - imem_addr = pc at all times.
- State machine:
  - REQ: accept -> WAIT; redirect -> stay REQ, pc <= redirect_pc; otherwise stay REQ.
  - WAIT:
    - redirect & imem_rvalid -> REQ; the response is discarded.
    - redirect without imem_rvalid -> DROP.
    - In both redirect cases pc <= redirect_pc.
    - imem_rvalid & accept -> WAIT.
    - imem_rvalid without accept -> REQ.
    - Otherwise stay WAIT.
  - DROP: imem_rvalid -> REQ, data discarded, never pushed. A further redirect updates pc and stays DROP.
- Redirect effects:
  - Flushes the whole queue in the same edge: count <= 0, valid_D = 0 next cycle.
  - Takes priority over a same-cycle push, pop and stall_D.
- Stall: while stall_D=1 the head entry and all Decode outputs hold; the queue keeps filling until full.
- Full queue: no request issued; the PC holds.
- Push and pop in the same cycle are legal at any occupancy, including full.
- Queue pointers wrap modulo FQ_DEPTH.
- Latency: accept at cycle t with rvalid at t+1 gives valid_D at t+2.

Test Plan:
- Reset, then 1-cycle memory with imem_ready=1, no stall, mem[i]=0x100+i:
  - valid_D rises 2 cycles after reset release.
  - PC_D = 0,1,2,3 on consecutive cycles; IR_out_D = 0x100.., PC_1D = PC_D+1.
- stall_D=1 for 5 cycles mid-stream, FQ_DEPTH=2:
  - Head holds.
  - imem_req drops once count=2 with nothing outstanding.
  - After release, no PC is skipped or duplicated.
- redirect_en with redirect_pc=0x40 while a request is outstanding (3-cycle memory):
  - Queue empties next cycle; the old response is discarded (DROP).
  - Next imem_addr = 0x40; first valid PC_D = 0x40.
- redirect_en on the same cycle as imem_rvalid:
  - Data is not pushed; state goes to REQ.
  - imem_req asserts next cycle with addr = redirect_pc.
- imem_ready=0 for 4 cycles: imem_req and imem_addr stay stable; the PC does not advance.
- Reset (rst=0) mid-WAIT, with a late rvalid after release: valid_D=0, the late data is ignored, fetch restarts at RESET_PC.
